// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared definitions for the instruction loader and control decoder
package instr_loader_pkg;

  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] ACK_INSTR = 9'b10_1111_111;

  localparam int ACC_W = 16;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/instr_loader_bit_packer.sv
// rtl/instr_loader_bit_packer.sv - LSB-first byte-to-word bit accumulator
module instr_loader_bit_packer
  import instr_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               accept,
  input  logic               drain,
  input  logic [7:0]         data,
  output logic [INSTR_W-1:0] word,
  output logic               full
);

  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(INSTR_W);
  localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  assign word = acc[INSTR_W-1:0];
  assign full = (cnt >= WORD_BITS);

  // accept only happens with cnt <= 8, so the shifted byte always fits in 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc | ({{(ACC_W-8){1'b0}}, data} << cnt);
      cnt <= cnt + BYTE_BITS;
    end else if (drain) begin
      acc <= acc >> INSTR_W;
      cnt <= cnt - WORD_BITS;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - packs a byte stream into 9-bit words and writes them to instruction memory
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [7:0]         InData,
  input  logic               InValid,
  output logic               InReady,
  output logic               InstrWrEn,
  output logic [ADDR_W-1:0]  InstrWrAddr,
  output logic [INSTR_W-1:0] InstrWrData,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [ADDR_W:0]    WordCount
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  loader_state_t     state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   wc;
  logic [INSTR_W-1:0] word;
  logic              full;
  logic              ready;
  logic              wr_en;
  logic              accept;

  instr_loader_bit_packer u_packer (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .clear  (Start),
    .accept (accept),
    .drain  (wr_en),
    .data   (InData),
    .word   (word),
    .full   (full)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Start overrides everything, including a write that would otherwise be due
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    wr_en      = 1'b0;
    if (state == LOAD) begin
      ready = !full;
      wr_en = full && !Start;
      if (wr_en) begin
        if (word == ACK_INSTR)     next_state = DONE;
        else if (addr == ADDR_MAX) next_state = ERR;
      end
    end
    if (Start) next_state = LOAD;
  end

  assign accept = InValid && ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr <= '0;
      wc   <= '0;
    end else if (Start) begin
      addr <= '0;
      wc   <= '0;
    end else if (wr_en) begin
      addr <= addr + 1'b1;
      wc   <= wc + 1'b1;
    end
  end

  assign InReady     = ready;
  assign InstrWrEn   = wr_en;
  assign InstrWrAddr = addr;
  assign InstrWrData = word;
  assign Busy        = (state == LOAD);
  assign Done        = (state == DONE);
  assign Err         = (state == ERR);
  assign WordCount   = wc;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - scoreboard bench for instr_loader at ADDR_W=10 and ADDR_W=2
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_start, a_valid;
  logic [7:0] a_data;
  logic       a_ready, a_wen, a_busy, a_done, a_err;
  logic [9:0] a_waddr;
  logic [8:0] a_wdata;
  logic [10:0] a_wc;

  logic       b_start, b_valid;
  logic [7:0] b_data;
  logic       b_ready, b_wen, b_busy, b_done, b_err;
  logic [1:0] b_waddr;
  logic [8:0] b_wdata;
  logic [2:0] b_wc;

  instr_loader #(.ADDR_W(10)) u_a (
    .Clk(clk), .Reset_n(rst_n), .Start(a_start), .InData(a_data), .InValid(a_valid),
    .InReady(a_ready), .InstrWrEn(a_wen), .InstrWrAddr(a_waddr), .InstrWrData(a_wdata),
    .Busy(a_busy), .Done(a_done), .Err(a_err), .WordCount(a_wc)
  );

  instr_loader #(.ADDR_W(2)) u_b (
    .Clk(clk), .Reset_n(rst_n), .Start(b_start), .InData(b_data), .InValid(b_valid),
    .InReady(b_ready), .InstrWrEn(b_wen), .InstrWrAddr(b_waddr), .InstrWrData(b_wdata),
    .Busy(b_busy), .Done(b_done), .Err(b_err), .WordCount(b_wc)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int a_last_wr = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_wen) begin
      logic [31:0] e;
      check("a_wr_pending", 32'(qa.size() > 0), 32'(1));
      check("a_ready_during_wr", 32'(a_ready), 32'(0));
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a_wr_addr_data", 32'({a_waddr, a_wdata}), e);
      end
      a_last_wr = cyc + 1;
    end
    if (b_wen) begin
      logic [31:0] e;
      check("b_wr_pending", 32'(qb.size() > 0), 32'(1));
      check("b_ready_during_wr", 32'(b_ready), 32'(0));
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_wr_addr_data", 32'({b_waddr, b_wdata}), e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int addr, input int data);
    qa.push_back(32'(addr * 512 + data));
  endtask

  task automatic push_b(input int addr, input int data);
    qb.push_back(32'(addr * 512 + data));
  endtask

  task automatic start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic start_b();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] d);
    int n = 0;
    a_data  = d;
    a_valid = 1'b1;
    while (!a_ready && n < 40) begin
      tick();
      n++;
    end
    check("a_send_ready", 32'(a_ready), 32'(1));
    tick();
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int n = 0;
    b_data  = d;
    b_valid = 1'b1;
    while (!b_ready && n < 40) begin
      tick();
      n++;
    end
    check("b_send_ready", 32'(b_ready), 32'(1));
    tick();
    b_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(qa.size() + qb.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; a_valid = 1'b0; a_data = 8'h00;
    b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_ready", 32'(a_ready), 32'(0));
    check("rst_busy", 32'(a_busy), 32'(0));
    check("rst_wc", 32'(a_wc), 32'(0));
    check("rst_done_err", 32'({a_done, a_err}), 32'(0));

    // packing: 34,12,AB -> 034@0, 189@1, 6 bits left over
    start_a();
    push_a(0, 9'h034);
    push_a(1, 9'h189);
    send_a(8'h34); send_a(8'h12); send_a(8'hAB);
    drain("pack_drain");
    check("pack_wc", 32'(a_wc), 32'(2));
    check("pack_cnt", 32'(u_a.u_packer.cnt), 32'(6));
    check("pack_busy", 32'(a_busy), 32'(1));

    // throughput: 9 zero bytes back to back -> 8 writes, last one 17 edges after Start
    start_a();
    for (int i = 0; i < 8; i++) push_a(i, 0);
    for (int i = 0; i < 9; i++) send_a(8'h00);
    drain("thru_drain");
    check("thru_cycles", 32'(a_last_wr - start_cyc), 32'(17));
    check("thru_wc", 32'(a_wc), 32'(8));

    // back-pressure: a dead cycle between bytes
    start_a();
    for (int i = 0; i < 8; i++) push_a(i, 0);
    for (int i = 0; i < 9; i++) begin
      send_a(8'h00);
      tick();
    end
    drain("bp0_drain");
    check("bp0_wc", 32'(a_wc), 32'(8));

    start_a();
    push_a(0, 9'h034);
    push_a(1, 9'h189);
    send_a(8'h34); tick(); tick();
    send_a(8'h12); tick();
    send_a(8'hAB); tick();
    drain("bp1_drain");
    check("bp1_wc", 32'(a_wc), 32'(2));

    // reset mid-load: the second write is pending when reset hits and must not appear
    start_a();
    push_a(0, 9'h001);
    send_a(8'h01); send_a(8'h02); send_a(8'h03);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen", 32'(a_wen), 32'(0));
    check("mid_rst_ready", 32'(a_ready), 32'(0));
    check("mid_rst_addr", 32'(a_waddr), 32'(0));
    check("mid_rst_data", 32'(a_wdata), 32'(0));
    check("mid_rst_flags", 32'({a_busy, a_done, a_err}), 32'(0));
    check("mid_rst_wc", 32'(a_wc), 32'(0));
    check("mid_rst_state", 32'(u_a.state), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_q", 32'(qa.size()), 32'(0));

    start_a();
    push_a(0, 9'h17F);
    send_a(8'h7F); send_a(8'h01);
    drain("halt_drain");
    tick();
    check("halt_done", 32'(a_done), 32'(1));
    check("halt_err", 32'(a_err), 32'(0));
    check("halt_busy_ready", 32'({a_busy, a_ready}), 32'(0));
    check("halt_wc", 32'(a_wc), 32'(1));

    // overflow on the 4-word instance
    start_b();
    for (int i = 0; i < 4; i++) push_b(i, 0);
    for (int i = 0; i < 5; i++) send_b(8'h00);
    drain("ovf_drain");
    repeat (3) tick();
    check("ovf_err", 32'(b_err), 32'(1));
    check("ovf_done", 32'(b_done), 32'(0));
    check("ovf_ready", 32'(b_ready), 32'(0));
    check("ovf_wc", 32'(b_wc), 32'(4));
    check("ovf_busy", 32'(b_busy), 32'(0));

    start_b();
    check("restart_err", 32'(b_err), 32'(0));
    check("restart_addr", 32'(b_waddr), 32'(0));
    check("restart_busy", 32'(b_busy), 32'(1));
    check("restart_wc", 32'(b_wc), 32'(0));

    // halt word lands on the last address: Done wins over Err
    for (int i = 0; i < 3; i++) push_b(i, 0);
    push_b(3, 9'h17F);
    send_b(8'h00); send_b(8'h00); send_b(8'h00); send_b(8'hF8); send_b(8'h0B);
    drain("lasthalt_drain");
    tick();
    check("lasthalt_done", 32'(b_done), 32'(1));
    check("lasthalt_err", 32'(b_err), 32'(0));
    check("lasthalt_wc", 32'(b_wc), 32'(4));

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
